// File: rtl/hazard_unit_if.sv
// hazard_unit_if
// Bundles the Decode/Execute hazard inputs and the stall/flush/status outputs
// of the hazard controller.
//   master : pipeline side; drives register ids and control, reads stalls/flushes
//   slave  : hazard controller side
// Signals:
//   Rs1D, Rs2D, RdD, RegWriteD, MduD   Decode instruction fields
//   RdE, ResultSrcE0, MduE, PCSrcE      Execute instruction fields / redirect
//   MduDone, CountClr                   MDU writeback pulse, counter clear
//   StallF, StallD, FlushD, FlushE      pipeline register controls
//   MduBusy, MduTimeout, StallCount     scoreboard and performance status
interface hazard_unit_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic        RegWriteD;
    logic        MduD;
    logic [4:0]  RdE;
    logic        ResultSrcE0;
    logic        MduE;
    logic        PCSrcE;
    logic        MduDone;
    logic        CountClr;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        MduBusy;
    logic        MduTimeout;
    logic [15:0] StallCount;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, MduD, RdE, ResultSrcE0, MduE,
               PCSrcE, MduDone, CountClr,
        input  StallF, StallD, FlushD, FlushE, MduBusy, MduTimeout, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, MduD, RdE, ResultSrcE0, MduE,
               PCSrcE, MduDone, CountClr,
        output StallF, StallD, FlushD, FlushE, MduBusy, MduTimeout, StallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit
// Decode-stage stall/flush controller. Detects load-use hazards, taken
// branch/jump redirects and dependences on the single outstanding iterative
// MDU operation, tracked by an IDLE/BUSY scoreboard with a sticky timeout
// watchdog. Also keeps a saturating count of stall cycles.
// Ports:
//   clk    pipeline clock
//   reset  synchronous active-high reset
//   hz     hazard_unit_if.slave (see interface header for signal list)
// Parameters:
//   MDU_TIMEOUT  cycles an MDU op may remain outstanding before MduTimeout sets
module hazard_unit #(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    hazard_unit_if.slave   hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_AGE = 16'(MDU_TIMEOUT - 1);
    localparam logic [15:0] SAT_MAX     = 16'hFFFF;

    state_t      state_reg;
    logic [4:0]  pend_rd_reg;
    logic [15:0] age_reg;
    logic        timeout_reg;
    logic [15:0] stall_count_reg;

    // Source operand comparisons, one lane per Decode source register.
    logic [1:0][4:0] src;
    logic [1:0]      hit_e;
    logic [1:0]      hit_pend;

    assign src = {hz.Rs2D, hz.Rs1D};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign hit_e[gi]    = (src[gi] == hz.RdE);
        assign hit_pend[gi] = (src[gi] == pend_rd_reg);
    end

    logic busy;
    logic rde_valid;
    logic pend_valid;
    logic lw_stall;
    logic mdu_issue_stall;
    logic mdu_raw_stall;
    logic mdu_struct;
    logic stall;

    assign busy       = (state_reg == BUSY);
    assign rde_valid  = (hz.RdE != 5'd0);
    assign pend_valid = (pend_rd_reg != 5'd0);

    assign lw_stall        = hz.ResultSrcE0 && rde_valid && (|hit_e);
    assign mdu_issue_stall = hz.MduE && rde_valid && (|hit_e);
    // The RdD term blocks a younger write to the pending register (WAW) so the
    // late MDU writeback cannot clobber it.
    assign mdu_raw_stall   = busy && pend_valid &&
                             ((|hit_pend) || (hz.RegWriteD && (hz.RdD == pend_rd_reg)));
    assign mdu_struct      = hz.MduD && (busy || hz.MduE);
    assign stall           = lw_stall || mdu_issue_stall || mdu_raw_stall || mdu_struct;

    // A redirect does not mask the stall: the flush of D already discards the
    // stalled instruction, so asserting both together is harmless.
    assign hz.StallF     = stall;
    assign hz.StallD     = stall;
    assign hz.FlushD     = hz.PCSrcE;
    assign hz.FlushE     = stall || hz.PCSrcE;
    assign hz.MduBusy    = busy;
    assign hz.MduTimeout = timeout_reg;
    assign hz.StallCount = stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pend_rd_reg     <= 5'd0;
            age_reg         <= 16'd0;
            timeout_reg     <= 1'b0;
            stall_count_reg <= 16'd0;
        end else begin
            // A new issue takes precedence over a completion in the same cycle:
            // the completing op is the old one, the new one is now outstanding.
            if (hz.MduE) begin
                state_reg   <= BUSY;
                pend_rd_reg <= hz.RdE;
                age_reg     <= 16'd0;
            end else if (busy) begin
                if (hz.MduDone) begin
                    state_reg <= IDLE;
                end
                if (age_reg != SAT_MAX) begin
                    age_reg <= age_reg + 16'd1;
                end
            end

            if (busy && (age_reg == TIMEOUT_AGE)) begin
                timeout_reg <= 1'b1;
            end

            if (hz.CountClr) begin
                stall_count_reg <= 16'd0;
            end else if (stall && (stall_count_reg != SAT_MAX)) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic clk;
    logic reset;

    hazard_unit_if bus ();

    hazard_unit #(.MDU_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regw;
        logic       mdud;
        logic [4:0] rde;
        logic       ld;
        logic       mdue;
        logic       pcsrc;
        logic       stall;
        logic       flushd;
        logic       flushe;
    } vec_t;

    vec_t vecs [13];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.Rs1D        = 5'd0;
        bus.Rs2D        = 5'd0;
        bus.RdD         = 5'd0;
        bus.RegWriteD   = 1'b0;
        bus.MduD        = 1'b0;
        bus.RdE         = 5'd0;
        bus.ResultSrcE0 = 1'b0;
        bus.MduE        = 1'b0;
        bus.PCSrcE      = 1'b0;
        bus.MduDone     = 1'b0;
        bus.CountClr    = 1'b0;
    endtask

    task automatic check_stall(input string name, input logic exp);
        check1({name, "_stallF"}, bus.StallF, exp);
        check1({name, "_stallD"}, bus.StallD, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //            name            rs1    rs2    rd     rw    mdud  rde    ld    mdue  pc    stall fd    fe
        vecs[0]  = '{"ld_rs1",        5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{"ld_rd0",        5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"ld_rs2",        5'd3,  5'd6,  5'd0,  1'b0, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{"ld_nomatch",    5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"mdu_issue",     5'd0,  5'd7,  5'd0,  1'b0, 1'b0, 5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{"mdu_issue_rd0", 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"mdu_struct",    5'd1,  5'd2,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{"mdud_idle",     5'd1,  5'd2,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"branch",        5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{"branch_ld",     5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{"ld_rd_only",    5'd1,  5'd0,  5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"idle_waw",      5'd0,  5'd0,  5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"plain_alu",     5'd4,  5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check1("rst_busy", bus.MduBusy, 1'b0);
        check1("rst_timeout", bus.MduTimeout, 1'b0);
        check16("rst_count", bus.StallCount, 16'd0);

        // Combinational vectors applied while reset holds the scoreboard IDLE.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.Rs1D        = vecs[i].rs1;
            bus.Rs2D        = vecs[i].rs2;
            bus.RdD         = vecs[i].rd;
            bus.RegWriteD   = vecs[i].regw;
            bus.MduD        = vecs[i].mdud;
            bus.RdE         = vecs[i].rde;
            bus.ResultSrcE0 = vecs[i].ld;
            bus.MduE        = vecs[i].mdue;
            bus.PCSrcE      = vecs[i].pcsrc;
            #1;
            check_stall(vecs[i].name, vecs[i].stall);
            check1({vecs[i].name, "_flushD"}, bus.FlushD, vecs[i].flushd);
            check1({vecs[i].name, "_flushE"}, bus.FlushE, vecs[i].flushe);
            $display("vec %0d %s: stall=%0b flushD=%0b flushE=%0b", i, vecs[i].name,
                     bus.StallD, bus.FlushD, bus.FlushE);
        end

        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        #1;
        check16("post_rst_count", bus.StallCount, 16'd0);

        // Load-use: one stall cycle, then the bubble reaches Execute.
        @(negedge clk);
        bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
        #1;
        check_stall("lu", 1'b1);
        check1("lu_flushE", bus.FlushE, 1'b1);
        check1("lu_flushD", bus.FlushD, 1'b0);
        @(negedge clk);
        bus.ResultSrcE0 = 1'b0; bus.RdE = 5'd0;
        #1;
        check_stall("lu_after", 1'b0);
        check1("lu_after_flushE", bus.FlushE, 1'b0);
        check16("lu_count", bus.StallCount, 16'd1);
        $display("load-use: count=%0d", bus.StallCount);

        // MDU RAW on Rs2D=7: issue cycle 0, MduDone in cycle 10, release in 11.
        @(negedge clk);
        clear_inputs();
        bus.MduE = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
        #1;
        check_stall("mdu_issue_c0", 1'b1);
        check1("mdu_busy_c0", bus.MduBusy, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.MduE    = 1'b0;
            bus.RdE     = 5'd0;
            bus.MduDone = (c == 10);
            #1;
            if (c <= 10) begin
                check_stall($sformatf("mdu_raw_c%0d", c), 1'b1);
                check1($sformatf("mdu_busy_c%0d", c), bus.MduBusy, 1'b1);
            end else begin
                check_stall("mdu_release", 1'b0);
                check1("mdu_idle", bus.MduBusy, 1'b0);
                check16("mdu_count", bus.StallCount, 16'd12);
            end
            check1($sformatf("wdog_c%0d", c), bus.MduTimeout, (c >= 5));
            $display("mdu cycle %0d: stall=%0b busy=%0b timeout=%0b", c,
                     bus.StallD, bus.MduBusy, bus.MduTimeout);
        end

        // Structural and WAW while BUSY with PendRd=9.
        @(negedge clk);
        clear_inputs();
        bus.MduE = 1'b1; bus.RdE = 5'd9;
        #1;
        check_stall("issue9", 1'b0);
        @(negedge clk);
        clear_inputs();
        bus.RdD = 5'd9;
        #1;
        check1("busy9", bus.MduBusy, 1'b1);
        check_stall("waw_noregw", 1'b0);
        @(negedge clk);
        clear_inputs();
        bus.MduD = 1'b1;
        #1;
        check_stall("struct_busy", 1'b1);
        @(negedge clk);
        clear_inputs();
        bus.RegWriteD = 1'b1; bus.RdD = 5'd9;
        #1;
        check_stall("waw", 1'b1);
        @(negedge clk);
        clear_inputs();
        bus.Rs1D = 5'd9;
        #1;
        check_stall("raw_pend9", 1'b1);
        check16("struct_count", bus.StallCount, 16'd14);
        $display("struct/waw: count=%0d", bus.StallCount);

        // Reset mid-BUSY forgets the outstanding op.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check1("rst_mid_busy", bus.MduBusy, 1'b0);
        check_stall("rst_mid_pend", 1'b0);
        check16("rst_mid_count", bus.StallCount, 16'd0);
        check1("rst_mid_timeout", bus.MduTimeout, 1'b0);
        $display("reset mid-busy: busy=%0b stall=%0b", bus.MduBusy, bus.StallD);

        // CountClr wins over a concurrent stall.
        @(negedge clk);
        clear_inputs();
        bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd5; bus.Rs1D = 5'd5;
        @(negedge clk);
        bus.CountClr = 1'b1;
        #1;
        check16("cnt_before_clr", bus.StallCount, 16'd1);
        @(negedge clk);
        bus.CountClr = 1'b0;
        #1;
        check16("cnt_clr_with_stall", bus.StallCount, 16'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        check16("cnt_after_clr", bus.StallCount, 16'd1);
        $display("count clear: count=%0d", bus.StallCount);

        // Three BUSY cycles stay below the watchdog limit.
        @(negedge clk);
        clear_inputs();
        bus.MduE = 1'b1; bus.RdE = 5'd12;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.MduDone = (c == 3);
            #1;
            check1($sformatf("short_busy_c%0d", c), bus.MduBusy, 1'b1);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check1("short_idle", bus.MduBusy, 1'b0);
        check1("short_no_timeout", bus.MduTimeout, 1'b0);

        // MduDone while IDLE is ignored.
        bus.MduDone = 1'b1;
        @(negedge clk);
        clear_inputs();
        #1;
        check1("done_idle", bus.MduBusy, 1'b0);

        // Issue and completion in the same BUSY cycle: new op stays outstanding.
        bus.MduE = 1'b1; bus.RdE = 5'd3;
        @(negedge clk);
        clear_inputs();
        bus.MduE = 1'b1; bus.RdE = 5'd4; bus.MduDone = 1'b1;
        @(negedge clk);
        clear_inputs();
        bus.Rs1D = 5'd4;
        #1;
        check1("reissue_busy", bus.MduBusy, 1'b1);
        check_stall("reissue_new_pend", 1'b1);
        bus.Rs1D = 5'd3;
        #1;
        check_stall("reissue_old_pend", 1'b0);
        $display("reissue: busy=%0b", bus.MduBusy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Decode-stage hazard controller for the 5-stage pipeline: the stalling and flushing counterpart to the Execute-stage forwarding logic, covering every case where a forward cannot supply the value in time. It detects load-use hazards, branch/jump redirects, and register dependences on the iterative multiply/divide unit (MDU). It tracks the single outstanding MDU destination in a two-state scoreboard with a timeout watchdog and keeps a stall-cycle performance counter. It drives the F/D enables and the D/E flushes of the pipeline registers.

## Interface
- MDU_TIMEOUT, 64: max cycles an MDU op may stay outstanding before MduTimeout sets
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Rs1D  in  5  source register 1 of instruction in Decode
- Rs2D  in  5  source register 2 of instruction in Decode
- RdD  in  5  destination of instruction in Decode
- RegWriteD  in  1  Decode instruction writes RdD
- MduD  in  1  Decode instruction is an MDU op
- RdE  in  5  destination of instruction in Execute
- ResultSrcE0  in  1  Execute instruction is a load
- MduE  in  1  Execute instruction is an MDU op (issues to MDU this cycle)
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MduDone  in  1  MDU result written back this cycle (single-cycle pulse)
- CountClr  in  1  synchronous clear of StallCount
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register (insert bubble)
- MduBusy  out  1  scoreboard state is BUSY
- MduTimeout  out  1  sticky watchdog error
- StallCount  out  16  saturating count of stall cycles

## Operation
- Scoreboard FSM, states IDLE and BUSY, holds PendRd[4:0] and a 16-bit age counter.
  - IDLE -> BUSY on MduE; PendRd <= RdE; age <= 0.
  - BUSY -> IDLE on MduDone.
  - In BUSY, age increments each cycle, saturating at 0xFFFF.
  - If MduE and MduDone occur in the same cycle, issue wins: the state stays or becomes BUSY with the new PendRd.
  - MduDone in IDLE is ignored.
- Hazard terms (combinational). A register matches only when it is nonzero.
  - lwStall = ResultSrcE0 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
  - mduIssueStall = MduE && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
  - mduRawStall = BUSY && PendRd!=0 && (Rs1D==PendRd || Rs2D==PendRd || (RegWriteD && RdD==PendRd)). The RdD term covers the WAW case.
  - mduStruct = MduD && (BUSY || MduE).
  - stall = OR of all four terms.
- Output equations:
  - StallF = StallD = stall.
  - FlushD = PCSrcE.
  - FlushE = stall || PCSrcE.
  - PCSrcE does not suppress stall. The flush already kills the stalled D instruction, so both are asserted together.
- mduRawStall is evaluated from the registered state only. The stall releases in the cycle after MduDone. The register file's write-before-read guarantees the value is correct at that point.
- Watchdog: when BUSY and age == MDU_TIMEOUT-1, MduTimeout <= 1. It stays set until reset and does not alter the FSM.
- StallCount:
  - CountClr has priority and sets the count to 0.
  - Otherwise the count increments on each cycle with StallD=1, saturating at 0xFFFF.

## Timing
- Reset values: state IDLE, PendRd 0, age 0, MduBusy 0, MduTimeout 0, StallCount 0. With IDLE state, StallF/StallD/FlushD/FlushE follow the input equations during reset.
- Stall and flush outputs are combinational with zero latency from inputs, so they are valid in the same cycle as their inputs.
- MduBusy rises in the cycle after MduE and falls in the cycle after MduDone.
- Load-use hazard: exactly one stall cycle plus one E bubble.
- MDU RAW hazard: stall is held from the cycle after issue through the cycle of MduDone.
- Reset asserted mid-operation: BUSY returns to IDLE on the next edge and the outstanding MDU op is forgotten.

## Test plan
- Load-use: ResultSrcE0=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle, FlushD=0. Repeat with RdE=0 -> no stall.
- MDU dependence: MduE=1 with RdE=7, then Rs2D=7 held.
  - Stall is asserted in the issue cycle and every BUSY cycle.
  - MduDone pulsed at cycle 10 -> stall deasserts at cycle 11 and MduBusy=0.
- Structural and WAW: while BUSY with PendRd=9:
  - MduD=1 -> stall.
  - RegWriteD=1, RdD=9 -> stall.
  - RdD=9 with RegWriteD=0 -> no stall.
- Branch during stall: lwStall active plus PCSrcE=1 -> FlushD=1, FlushE=1, StallD=1.
- Watchdog and counter, with MDU_TIMEOUT=4:
  - Issue with no MduDone -> MduTimeout=1 after the 4th BUSY cycle and stays 1 after a later MduDone.
  - StallCount equals the number of stall cycles; CountClr together with a stall -> 0.
- Reset mid-BUSY -> next cycle MduBusy=0, PendRd ignored (Rs1D=PendRd gives no stall), StallCount=0.
